// File: rtl/vga_fetch_pkg.sv
// Shared constants and types for the VGA read-side prefetcher.
// Pixel-half ordering: the even-x pixel sits in the high half of a memory word,
// the odd-x pixel in the low half; the NTSC packer relies on the same layout.
package vga_fetch_pkg;

  localparam int unsigned LOG_MEM        = 36;      // memory word width
  localparam int unsigned PIX_W          = 18;      // pixel width, two per word
  localparam int unsigned FETCH_DEPTH    = 8;       // prefetch FIFO words
  localparam int unsigned MEM_READ_LAT   = 2;       // done_vga -> read data cycles
  localparam int unsigned IMAGE_LENGTH   = 153600;  // words per frame
  localparam int unsigned IMAGE_WIDTH_D2 = 320;     // words per display line
  localparam int unsigned STAT_W         = 16;      // underflow counter width

  // One memory word: even pixel first (MSBs), odd pixel second (LSBs).
  typedef struct packed {
    logic [PIX_W-1:0] even;
    logic [PIX_W-1:0] odd;
  } mem_word_t;

  // Which half of the head word is delivered next.
  typedef enum logic {
    HALF_EVEN = 1'b0,
    HALF_ODD  = 1'b1
  } half_e;

endpackage

// File: rtl/vga_fetch_if.sv
// Read-request handshake between vga_fetch (master) and memory_interface (slave).
//   vga_flag  : read request, driven by the fetcher
//   done_vga  : request accepted this cycle
//   vga_pixel : read data, valid a fixed latency after acceptance
interface vga_fetch_if;
  import vga_fetch_pkg::*;

  logic      vga_flag;
  logic      done_vga;
  mem_word_t vga_pixel;

  modport master (output vga_flag, input done_vga, input vga_pixel);
  modport slave  (input vga_flag, output done_vga, output vga_pixel);

endinterface

// File: rtl/vga_fetch_fifo.sv
// First-word fall-through FIFO of memory words.
//   clock, reset : system clock, synchronous active-high reset
//   push, din    : write one word
//   pop          : consume the word shown on dout
//   flush        : empty the FIFO; wins over push and pop
//   dout         : current head word (combinational)
//   count        : words stored
module vga_fetch_fifo
  import vga_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  mem_word_t              din,
  output mem_word_t              dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mem_word_t        store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the head leaves the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only pointers qualify it.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= din;
  end

  assign dout = store[rd_ptr];

endmodule

// File: rtl/vga_fetch.sv
// Read-side prefetcher feeding the VGA pixel pipeline.
// Issues credit-limited read requests, tracks the fixed read latency, buffers
// returned words and unpacks them into one pixel per pix_req.
//   clock, reset     : system clock, synchronous active-high reset
//   frame_flag       : frame-swap pulse; restarts fetching for the new frame
//   mem              : vga_fetch_if.master (vga_flag / done_vga / vga_pixel)
//   pix_req          : display consumes one pixel this cycle
//   pix_out          : registered pixel
//   pix_valid        : pix_out holds a real pixel
//   underflow        : sticky, set when pix_req finds no data
//   underflow_count  : saturating underflow event count
// Build option: define VGA_FETCH_STATS_EN to build the underflow counter;
// otherwise underflow_count is tied to zero.
module vga_fetch
  import vga_fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = FETCH_DEPTH,
  parameter int unsigned READ_LAT        = MEM_READ_LAT,
  parameter int unsigned WORDS_PER_FRAME = IMAGE_LENGTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_flag,
  vga_fetch_if.master        mem,
  input  logic               pix_req,
  output logic [PIX_W-1:0]   pix_out,
  output logic               pix_valid,
  output logic               underflow,
  output logic [STAT_W-1:0]  underflow_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned WL_W  = $clog2(WORDS_PER_FRAME + 1);

  logic                restart;
  logic [WL_W-1:0]     words_left;
  logic [READ_LAT-1:0] inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    inflight_count;
  logic [SUM_W-1:0]    credit_used;
  logic                fifo_empty;
  logic                vga_flag_c;
  logic                accept;
  logic                push;
  logic                pop;
  logic                pix_avail;
  half_e               half;
  mem_word_t           head;

  assign restart = reset || frame_flag;

  // Request credit uses registered state only, never done_vga, to keep the
  // arbiter free of a combinational loop.
  always_comb begin
    inflight_count = CNT_W'($countones(inflight));
    credit_used    = SUM_W'(fifo_count) + SUM_W'(inflight_count);
    fifo_empty     = (fifo_count == '0);
    vga_flag_c     = !restart && (words_left != '0) &&
                     (credit_used < SUM_W'(FIFO_DEPTH));
    accept         = vga_flag_c && mem.done_vga;
    push           = inflight[READ_LAT-1];
    pix_avail      = pix_req && !restart && !fifo_empty;
    pop            = pix_avail && (half == HALF_ODD);
  end

  assign mem.vga_flag = vga_flag_c;

  // Frame progress, read-latency tracking and half selection.
  always_ff @(posedge clock) begin
    if (restart) begin
      words_left <= WL_W'(WORDS_PER_FRAME);
      inflight   <= '0;
      half       <= HALF_EVEN;
    end else begin
      if (accept) words_left <= words_left - WL_W'(1);
      inflight <= READ_LAT'({inflight, accept});
      if (pix_avail) half <= (half == HALF_EVEN) ? HALF_ODD : HALF_EVEN;
    end
  end

  // Returned data is qualified only by the in-flight tracker; vga_pixel is
  // stale between reads.
  vga_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (restart),
    .din   (mem.vga_pixel),
    .dout  (head),
    .count (fifo_count)
  );

  // Pixel output; a starved request or one on a frame swap emits an empty slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
    end else if (pix_req) begin
      if (pix_avail) begin
        pix_out   <= (half == HALF_EVEN) ? head.even : head.odd;
        pix_valid <= 1'b1;
      end else begin
        pix_out   <= '0;
        pix_valid <= 1'b0;
        if (!frame_flag) underflow <= 1'b1;
      end
    end else begin
      pix_valid <= 1'b0;
    end
  end

`ifdef VGA_FETCH_STATS_EN
  // Saturating count of starved requests, cleared by reset only.
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_count <= '0;
    end else if (pix_req && !frame_flag && fifo_empty && (underflow_count != '1)) begin
      underflow_count <= underflow_count + STAT_W'(1);
    end
  end
`else
  assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_vga_fetch.sv
// Directed bench for vga_fetch: a cycle table for cold start and steady
// streaming, then hand-written sequences for starvation, fill, reset and
// frame swap, plus a second instance with a 4-word frame.
module tb_vga_fetch;
  import vga_fetch_pkg::*;

  localparam int unsigned DEPTH = FETCH_DEPTH;
`ifdef VGA_FETCH_STATS_EN
  localparam int unsigned EXP_UCNT = 5;
`else
  localparam int unsigned EXP_UCNT = 0;
`endif

  typedef struct {
    logic [3:0]       in_bits;   // {reset, frame_flag, done_vga, pix_req}
    logic             exp_flag;
    logic             exp_valid;
    logic [PIX_W-1:0] exp_out;
    logic             exp_uf;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              frame_flag = 1'b0;
  logic              pix_req = 1'b0;
  logic [PIX_W-1:0]  pix_out;
  logic              pix_valid;
  logic              underflow;
  logic [STAT_W-1:0] underflow_count;

  logic              pix_req4 = 1'b1;
  logic [PIX_W-1:0]  pix_out4;
  logic              pix_valid4;
  logic              underflow4;
  logic [STAT_W-1:0] underflow_count4;

  int errors = 0;
  int checks = 0;
  bit inv_on = 1'b0;

  vga_fetch_if m();
  vga_fetch_if m4();

  always #5 clock = ~clock;

  vga_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .frame_flag      (frame_flag),
    .mem             (m),
    .pix_req         (pix_req),
    .pix_out         (pix_out),
    .pix_valid       (pix_valid),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  vga_fetch #(.WORDS_PER_FRAME(4)) dut4 (
    .clock           (clock),
    .reset           (reset),
    .frame_flag      (frame_flag),
    .mem             (m4),
    .pix_req         (pix_req4),
    .pix_out         (pix_out4),
    .pix_valid       (pix_valid4),
    .underflow       (underflow4),
    .underflow_count (underflow_count4)
  );

  // Word n of a frame holds pixels 16n+1 (even) and 16n+3 (odd).
  function automatic mem_word_t word_at(input int unsigned n);
    mem_word_t w;
    w.even = PIX_W'(16 * n + 1);
    w.odd  = PIX_W'(16 * n + 3);
    return w;
  endfunction

  function automatic logic [PIX_W-1:0] pix_at(input int unsigned p);
    mem_word_t w;
    w = word_at(p / 2);
    return (p % 2 == 0) ? w.even : w.odd;
  endfunction

  function automatic vec_t mk(input logic [3:0] in_bits, input logic f, input logic v,
                              input logic [PIX_W-1:0] o, input logic u);
    vec_t r;
    r.in_bits = in_bits; r.exp_flag = f; r.exp_valid = v; r.exp_out = o; r.exp_uf = u;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, away from the active edge.
  task automatic step(input logic rst, input logic ff, input logic done, input logic req);
    @(negedge clock);
    reset = rst; frame_flag = ff; m.done_vga = done; pix_req = req;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory model: address follows the frame rotation, data two cycles after grant.
  int unsigned addr = 0, addr4 = 0;
  mem_word_t   stage = '0, stage4 = '0;

  always @(posedge clock) begin
    if (reset || frame_flag) addr <= 0;
    else if (m.vga_flag && m.done_vga) addr <= addr + 1;
    if (m.vga_flag && m.done_vga) stage <= word_at(addr);
    m.vga_pixel <= stage;

    if (reset || frame_flag) addr4 <= 0;
    else if (m4.vga_flag && m4.done_vga) addr4 <= addr4 + 1;
    if (m4.vga_flag && m4.done_vga) stage4 <= word_at(addr4);
    m4.vga_pixel <= stage4;
  end

  // Pixel-order scoreboard: every valid pixel must be the next one of the frame.
  int unsigned sb_n = 0;
  always @(posedge clock) begin
    logic rs;
    rs = reset || frame_flag;
    #1;
    if (rs) sb_n = 0;
    else if (pix_valid) begin
      check("pix_order", 64'(pix_out), 64'(pix_at(sb_n)));
      sb_n++;
    end
  end

  // Grant and pixel counters for the 4-word-frame instance.
  int unsigned g4 = 0, p4 = 0;
  always @(posedge clock) begin
    logic rs, gr;
    rs = reset || frame_flag;
    gr = m4.vga_flag && m4.done_vga;
    #1;
    if (rs) begin
      g4 = 0; p4 = 0;
    end else begin
      if (gr) g4++;
      if (pix_valid4) p4++;
    end
  end

  // Credit bound and FIFO overflow invariants.
  always begin
    @(negedge clock);
    #3;
    if (inv_on) begin
      check("credit_bound",
            64'((int'(dut.fifo_count) + int'(dut.inflight_count)) <= int'(DEPTH)), 64'd1);
      check("credit_bound4",
            64'((int'(dut4.fifo_count) + int'(dut4.inflight_count)) <= int'(DEPTH)), 64'd1);
      check("fifo_overflow",
            64'(dut.push && !dut.pop && (int'(dut.fifo_count) == int'(DEPTH))), 64'd0);
    end
  end

  initial begin
    vec_t vq[$];
    m.done_vga  = 1'b1;
    m4.done_vga = 1'b1;

    // Cold start: grant every cycle, pix_req every other cycle from cycle 3.
    vq.push_back(mk(4'b1011, 1'b0, 1'b0, 18'h00000, 1'b0));
    vq.push_back(mk(4'b1011, 1'b0, 1'b0, 18'h00000, 1'b0));
    vq.push_back(mk(4'b0010, 1'b1, 1'b0, 18'h00000, 1'b0));  // c0
    vq.push_back(mk(4'b0010, 1'b1, 1'b0, 18'h00000, 1'b0));  // c1
    vq.push_back(mk(4'b0010, 1'b1, 1'b0, 18'h00000, 1'b0));  // c2
    vq.push_back(mk(4'b0011, 1'b1, 1'b1, 18'h00001, 1'b0));  // c3 first pixel
    vq.push_back(mk(4'b0010, 1'b1, 1'b0, 18'h00001, 1'b0));  // c4 holds
    vq.push_back(mk(4'b0011, 1'b1, 1'b1, 18'h00003, 1'b0));  // c5 odd half
    vq.push_back(mk(4'b0010, 1'b1, 1'b0, 18'h00003, 1'b0));  // c6
    vq.push_back(mk(4'b0011, 1'b1, 1'b1, 18'h00011, 1'b0));  // c7
    vq.push_back(mk(4'b0010, 1'b1, 1'b0, 18'h00011, 1'b0));  // c8
    vq.push_back(mk(4'b0011, 1'b0, 1'b1, 18'h00013, 1'b0));  // c9 credit full
    vq.push_back(mk(4'b0010, 1'b1, 1'b0, 18'h00013, 1'b0));  // c10
    vq.push_back(mk(4'b0011, 1'b0, 1'b1, 18'h00021, 1'b0));  // c11 credit full

    foreach (vq[i]) begin
      step(vq[i].in_bits[3], vq[i].in_bits[2], vq[i].in_bits[1], vq[i].in_bits[0]);
      check($sformatf("vec%0d_flag", i), 64'(m.vga_flag), 64'(vq[i].exp_flag));
      tick();
      inv_on = 1'b1;
      check($sformatf("vec%0d_valid", i), 64'(pix_valid), 64'(vq[i].exp_valid));
      check($sformatf("vec%0d_out", i), 64'(pix_out), 64'(vq[i].exp_out));
      check($sformatf("vec%0d_uf", i), 64'(underflow), 64'(vq[i].exp_uf));
    end

    // Starved grants: 15 buffered pixels remain, then 5 empty requests.
    for (int s = 0; s < 20; s++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      if (s == 14) begin
        check("starve_last_valid", 64'(pix_valid), 64'd1);
        check("starve_last_pix", 64'(pix_out), 64'(18'h00093));
        check("starve_uf_clear", 64'(underflow), 64'd0);
      end
      if (s == 15) begin
        check("starve_empty_valid", 64'(pix_valid), 64'd0);
        check("starve_empty_out", 64'(pix_out), 64'd0);
        check("starve_uf_set", 64'(underflow), 64'd1);
      end
    end
    check("starve_flag", 64'(m.vga_flag), 64'd1);
    check("starve_ucount", 64'(underflow_count), 64'(EXP_UCNT));

    // Short frame instance: exactly 4 grants, 8 pixels, then silent.
    check("frame4_grants", 64'(g4), 64'd4);
    check("frame4_pixels", 64'(p4), 64'd8);
    check("frame4_flag_idle", 64'(m4.vga_flag), 64'd0);

    // Fill with grants forced high and no demand: FIFO reaches depth, flag drops.
    for (int r = 0; r < 15; r++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (r == 14) check("full_flag", 64'(m.vga_flag), 64'd0);
      tick();
    end
    check("full_count", 64'(dut.fifo_count), 64'(DEPTH));

    // Drain a few: pairing continues with the even half of word 10.
    for (int r = 0; r < 6; r++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      if (r == 0) begin
        check("recover_valid", 64'(pix_valid), 64'd1);
        check("recover_pix", 64'(pix_out), 64'(18'h000A1));
      end
    end
    check("uf_sticky", 64'(underflow), 64'd1);

    // Mid-stream reset: everything clears.
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("rst_flag", 64'(m.vga_flag), 64'd0);
      tick();
      check("rst_valid", 64'(pix_valid), 64'd0);
      check("rst_out", 64'(pix_out), 64'd0);
      check("rst_uf", 64'(underflow), 64'd0);
      check("rst_ucount", 64'(underflow_count), 64'd0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_flag", 64'(m.vga_flag), 64'd1);
    check("restart_words", 64'(dut.words_left), 64'(IMAGE_LENGTH));
    tick();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Frame swap with two reads in flight; pix_req on the swap cycle.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("ff_flag", 64'(m.vga_flag), 64'd0);
    check("ff_flag4", 64'(m4.vga_flag), 64'd0);
    tick();
    check("ff_fifo", 64'(dut.fifo_count), 64'd0);
    check("ff_valid", 64'(pix_valid), 64'd0);
    check("ff_uf", 64'(underflow), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ff_next_flag", 64'(m.vga_flag), 64'd1);
    check("ff_next_flag4", 64'(m4.vga_flag), 64'd1);
    tick();
    check("ff_discard1", 64'(dut.fifo_count), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("ff_discard2", 64'(dut.fifo_count), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("ff_first_push", 64'(dut.fifo_count), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("ff_new_pix", 64'(pix_out), 64'(18'h00001));
    check("ff_new_valid", 64'(pix_valid), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("ff_new_pix2", 64'(pix_out), 64'(18'h00003));

    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    inv_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
